// File: rtl/exp_pulse_gen.sv
// exp_pulse_gen: synthetic detector-pulse source for the shaping-filter chain.
// It produces a baseline plus exponentially decaying pulses. Pulses can be
// single-shot or periodic, and they pile up when they overlap. The stream is
// in the ADC sample format and feeds the filter input directly.

package package_settings;
    localparam int SIZE_ADC_DATA = 13;
endpackage

module exp_pulse_gen
    import package_settings::*;
#(
    parameter int DATA_W      = SIZE_ADC_DATA + 1,
    parameter int FRAC_W      = 8,
    parameter int DECAY_SHIFT = 4,
    parameter int PERIOD_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [DATA_W-1:0]   amplitude,
    input  logic [DATA_W-1:0]   baseline,
    input  logic [PERIOD_W-1:0] period,
    output logic                ready,
    output logic [DATA_W-1:0]   output_data,
    output logic                pulse_mark,
    output logic [15:0]         pulse_count
);

    localparam int ACC_W = DATA_W + FRAC_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEAK  = 2'd1,
        DECAY = 2'd2
    } state_t;

    // Registered state
    state_t              state_q,    state_d;
    logic [ACC_W-1:0]    acc_q,      acc_d;
    logic [PERIOD_W-1:0] cnt_q,      cnt_d;
    logic [PERIOD_W-1:0] period_q,   period_d;
    logic [DATA_W-1:0]   amp_q,      amp_d;
    logic                periodic_q, periodic_d;
    logic                ready_q,    ready_d;
    logic [DATA_W-1:0]   out_q,      out_d;
    logic                mark_q,     mark_d;
    logic [15:0]         count_q,    count_d;

    // Combinational helpers
    logic                extTrig;
    logic                autoTrig;
    logic                trigger;
    logic [DATA_W-1:0]   addAmp;
    logic [ACC_W:0]      sumWide;
    logic [ACC_W-1:0]    accSat;
    logic [ACC_W-1:0]    accDecayed;
    logic [DATA_W-1:0]   accInt;
    logic [DATA_W:0]     outSum;
    logic [PERIOD_W-1:0] periodLast;

    assign periodLast = period_q - PERIOD_W'(1);
    assign accInt     = acc_q[ACC_W-1:FRAC_W];

    // Trigger sources: the external start and the periodic auto trigger.
    // Stop vetoes a coincident auto trigger. A coincident external start
    // folds into one trigger, so only one add and one count occur.
    always_comb begin
        extTrig  = start && ready_q;
        autoTrig = periodic_q && !stop && (state_q != PEAK) && (cnt_q == periodLast);
        trigger  = extTrig || autoTrig;
    end

    // Saturating pulse add and one decay step, both computed from the current accumulator.
    always_comb begin
        addAmp     = extTrig ? amplitude : amp_q;
        sumWide    = {1'b0, acc_q} + {1'b0, addAmp, {FRAC_W{1'b0}}};
        accSat     = sumWide[ACC_W] ? {ACC_W{1'b1}} : sumWide[ACC_W-1:0];
        accDecayed = acc_q - (acc_q >> DECAY_SHIFT);
    end

    // Next-state logic for the pulse FSM, the repeat counter and the registered outputs.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        amp_d      = amp_q;
        periodic_d = periodic_q;
        count_d    = count_q;
        mark_d     = 1'b0;

        if (trigger) begin
            state_d = PEAK;
            acc_d   = accSat;
            cnt_d   = '0;
            mark_d  = 1'b1;
            count_d = count_q + 16'd1;
        end else begin
            if (periodic_q) begin
                cnt_d = cnt_q + PERIOD_W'(1);
            end
            case (state_q)
                PEAK: begin
                    state_d = DECAY;
                    acc_d   = accDecayed;
                end
                DECAY: begin
                    if (accInt == '0) begin
                        state_d = IDLE;
                        acc_d   = '0;
                    end else begin
                        acc_d = accDecayed;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                end
            endcase
        end

        if (extTrig) begin
            amp_d      = amplitude;
            period_d   = period;
            periodic_d = (period != '0);
        end
        if (stop) begin
            periodic_d = 1'b0;
        end

        ready_d = (state_d != PEAK);
        outSum  = {1'b0, baseline} + {1'b0, acc_d[ACC_W-1:FRAC_W]};
        out_d   = outSum[DATA_W] ? {DATA_W{1'b1}} : outSum[DATA_W-1:0];
    end

    // State register. Reset is synchronous and active low, and it aborts any pulse or periodic run.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            period_q   <= '0;
            amp_q      <= '0;
            periodic_q <= 1'b0;
            ready_q    <= 1'b0;
            out_q      <= '0;
            mark_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            amp_q      <= amp_d;
            periodic_q <= periodic_d;
            ready_q    <= ready_d;
            out_q      <= out_d;
            mark_q     <= mark_d;
            count_q    <= count_d;
        end
    end

    assign ready       = ready_q;
    assign output_data = out_q;
    assign pulse_mark  = mark_q;
    assign pulse_count = count_q;

endmodule

// File: tb/tb_exp_pulse_gen.sv
// Directed testbench for exp_pulse_gen. The expected samples are worked out
// by hand for DATA_W=14, FRAC_W=8 and DECAY_SHIFT=4.

module tb_exp_pulse_gen;

    localparam int DW   = package_settings::SIZE_ADC_DATA + 1;
    localparam int MAXV = (1 << DW) - 1;

    logic          clk;
    logic          reset;
    logic          start;
    logic          stop;
    logic [DW-1:0] amplitude;
    logic [DW-1:0] baseline;
    logic [15:0]   period;
    logic          ready;
    logic [DW-1:0] output_data;
    logic          pulse_mark;
    logic [15:0]   pulse_count;

    int vectors;
    int miscompares;

    exp_pulse_gen dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .amplitude   (amplitude),
        .baseline    (baseline),
        .period      (period),
        .ready       (ready),
        .output_data (output_data),
        .pulse_mark  (pulse_mark),
        .pulse_count (pulse_count)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 ns past the last one
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Compare one observed value with its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Let the output decay to target within a cycle budget.
    // Track monotonic decay, and check that ready stays high and pulse_mark stays low.
    task automatic waitSettle(input string tag, input logic [31:0] target);
        int steps;
        bit mono;
        bit quiet;
        logic [DW-1:0] prev;
        steps = 0;
        mono  = 1'b1;
        quiet = 1'b1;
        prev  = output_data;
        while (32'(output_data) !== target && steps < 400) begin
            applyStimulus(1);
            steps++;
            if (output_data > prev) mono = 1'b0;
            if (pulse_mark !== 1'b0 || ready !== 1'b1) quiet = 1'b0;
            prev = output_data;
        end
        checkOutput({tag, " settle"}, 32'(output_data), target);
        checkOutput({tag, " monotonic"}, 32'(mono), 1);
        checkOutput({tag, " quiet"}, 32'(quiet), 1);
    endtask

    // Guard against a hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        bit noMark;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        amplitude   = '0;
        baseline    = DW'(100);
        period      = '0;

        // Reset and baseline
        applyStimulus(2);
        checkOutput("reset out",   32'(output_data), 0);
        checkOutput("reset ready", 32'(ready), 0);
        checkOutput("reset mark",  32'(pulse_mark), 0);
        checkOutput("reset count", 32'(pulse_count), 0);
        reset = 1'b1;
        applyStimulus(1);
        checkOutput("release out",   32'(output_data), 100);
        checkOutput("release ready", 32'(ready), 1);
        checkOutput("release count", 32'(pulse_count), 0);

        // Single pulse
        amplitude = DW'(1000);
        start     = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("single peak",  32'(output_data), 1100);
        checkOutput("single mark",  32'(pulse_mark), 1);
        checkOutput("single ready", 32'(ready), 0);
        checkOutput("single count", 32'(pulse_count), 1);
        applyStimulus(1);
        checkOutput("single d1",    32'(output_data), 1037);
        checkOutput("single mark0", 32'(pulse_mark), 0);
        checkOutput("single ready1", 32'(ready), 1);
        applyStimulus(1);
        checkOutput("single d2", 32'(output_data), 978);

        // Pile-up on the 978 residual
        amplitude = DW'(500);
        start     = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("pileup peak",  32'(output_data), 1478);
        checkOutput("pileup mark",  32'(pulse_mark), 1);
        checkOutput("pileup count", 32'(pulse_count), 2);
        applyStimulus(1);
        checkOutput("pileup d1", 32'(output_data), 1392);
        waitSettle("pileup", 100);
        applyStimulus(3);
        checkOutput("pileup rest",  32'(output_data), 100);
        checkOutput("pileup count2", 32'(pulse_count), 2);

        // Accumulator saturation with zero baseline
        baseline  = '0;
        amplitude = DW'(MAXV);
        start     = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("sat peak1", 32'(output_data), MAXV);
        checkOutput("sat count1", 32'(pulse_count), 3);
        applyStimulus(1);
        checkOutput("sat d1", 32'(output_data), 15359);
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("sat peak2",  32'(output_data), MAXV);
        checkOutput("sat count2", 32'(pulse_count), 4);
        applyStimulus(1);
        checkOutput("sat acc clamp", 32'(output_data), 15360);

        // Output saturation against a high baseline
        baseline = DW'(MAXV - 100);
        applyStimulus(1);
        checkOutput("sat out clamp", 32'(output_data), MAXV);
        waitSettle("sat", MAXV - 100);

        // Periodic mode with period 50, stopped after the third auto trigger
        baseline = DW'(100);
        applyStimulus(1);
        checkOutput("baseline follow", 32'(output_data), 100);
        amplitude = DW'(200);
        period    = 16'd50;
        start     = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("periodic peak",  32'(output_data), 300);
        checkOutput("periodic count0", 32'(pulse_count), 5);
        for (int k = 1; k <= 150; k++) begin
            applyStimulus(1);
            checkOutput("periodic mark", 32'(pulse_mark), 32'(k % 50 == 0));
        end
        checkOutput("periodic count", 32'(pulse_count), 8);
        stop = 1'b1;
        applyStimulus(1);
        stop   = 1'b0;
        noMark = 1'b1;
        for (int k = 0; k < 200; k++) begin
            applyStimulus(1);
            if (pulse_mark !== 1'b0) noMark = 1'b0;
        end
        checkOutput("stopped no mark", 32'(noMark), 1);
        checkOutput("stopped count",   32'(pulse_count), 8);
        checkOutput("stopped out",     32'(output_data), 100);

        // Coincident start and auto trigger with period 120
        period = 16'd120;
        start  = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("coinc first", 32'(pulse_count), 9);
        applyStimulus(119);
        checkOutput("coinc idle out", 32'(output_data), 100);
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("coinc peak",  32'(output_data), 300);
        checkOutput("coinc mark",  32'(pulse_mark), 1);
        checkOutput("coinc count", 32'(pulse_count), 10);
        applyStimulus(1);
        checkOutput("coinc d1", 32'(output_data), 287);

        // Stop coincident with an auto trigger suppresses it
        applyStimulus(118);
        stop = 1'b1;
        applyStimulus(1);
        stop = 1'b0;
        checkOutput("veto mark",  32'(pulse_mark), 0);
        checkOutput("veto count", 32'(pulse_count), 10);
        noMark = 1'b1;
        for (int k = 0; k < 130; k++) begin
            applyStimulus(1);
            if (pulse_mark !== 1'b0) noMark = 1'b0;
        end
        checkOutput("veto no mark", 32'(noMark), 1);

        // Reset during decay
        amplitude = DW'(1000);
        period    = '0;
        start     = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        applyStimulus(3);
        reset = 1'b0;
        applyStimulus(1);
        checkOutput("midreset out",   32'(output_data), 0);
        checkOutput("midreset ready", 32'(ready), 0);
        checkOutput("midreset count", 32'(pulse_count), 0);
        checkOutput("midreset mark",  32'(pulse_mark), 0);
        reset = 1'b1;
        applyStimulus(1);
        checkOutput("midreset release", 32'(output_data), 100);
        checkOutput("midreset ready1",  32'(ready), 1);
        applyStimulus(3);
        checkOutput("midreset no residual", 32'(output_data), 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
